// File: rtl/fivediv_pkg.sv
// Shared types and arithmetic for the mod-5 serial frame encoder and checker.
package fivediv_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND_DATA  = 2'd1,
        SEND_CHECK = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam int MOD   = 5;
    localparam int CHK_W = 3;

    // One MSB-first step of a running remainder: (2r + b) mod 5.
    // With r in 0..4 the sum is at most 9, so one conditional subtract suffices.
    function automatic logic [2:0] next_residue(input logic [2:0] r, input logic b);
        logic [3:0] t;
        t = {r, b};
        return (t >= 4'(MOD)) ? 3'(t - 4'(MOD)) : t[2:0];
    endfunction

endpackage

// File: rtl/mod5_residue.sv
// Serial mod-5 residue register: clear, or absorb one MSB-first bit per step.
// Shared by the frame encoder and the serial divisibility checker.
module mod5_residue
    import fivediv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       step,
    input  logic       bit_in,
    output logic [2:0] r
);

    // Residue state; clear wins over step so a new frame always starts at zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r <= '0;
        end else if (clr) begin
            r <= '0;
        end else if (step) begin
            r <= next_residue(r, bit_in);
        end
    end

endmodule

// File: rtl/fivediv_enc.sv
// Serial frame encoder: DATA_W payload bits then 3 check bits, MSB first,
// chosen so the whole (DATA_W+3)-bit frame is a multiple of 5.
module fivediv_enc
    import fivediv_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              s,
    output logic              s_valid,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + CHK_W);

    state_t             state;
    logic [DATA_W-1:0]  sh;
    logic [DATA_W-1:0]  sh_shl;
    logic [CHK_W-1:0]   chk;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         res;
    logic [2:0]         res_last;
    logic [CHK_W-1:0]   chk_val;
    logic               res_clr;
    logic               res_step;

    assign sh_shl   = sh << 1;
    assign res_clr  = (state == IDLE) && start;
    assign res_step = (state == SEND_DATA);

    // Residue including the bit on the wire now; the check value is that doubled mod 5,
    // because appending 3 zero bits multiplies by 8 and -8 mod 5 = 2.
    assign res_last = next_residue(res, sh[DATA_W-1]);
    assign chk_val  = next_residue(res_last, 1'b0);

    mod5_residue u_res (
        .clk    (clk),
        .reset  (reset),
        .clr    (res_clr),
        .step   (res_step),
        .bit_in (sh[DATA_W-1]),
        .r      (res)
    );

    // Frame sequencer with registered serial output and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            s       <= 1'b0;
            s_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    s       <= 1'b0;
                    s_valid <= 1'b0;
                    busy    <= 1'b0;
                    if (start) begin
                        sh      <= data;
                        s       <= data[DATA_W-1];
                        s_valid <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= CNT_W'(DATA_W - 1);
                        state   <= SEND_DATA;
                    end
                end
                SEND_DATA: begin
                    sh <= sh_shl;
                    if (cnt != '0) begin
                        s   <= sh_shl[DATA_W-1];
                        cnt <= cnt - 1'b1;
                    end else begin
                        s     <= chk_val[CHK_W-1];
                        chk   <= {chk_val[CHK_W-2:0], 1'b0};
                        cnt   <= CNT_W'(CHK_W - 1);
                        state <= SEND_CHECK;
                    end
                end
                SEND_CHECK: begin
                    if (cnt != '0) begin
                        s   <= chk[CHK_W-1];
                        chk <= chk << 1;
                        cnt <= cnt - 1'b1;
                    end else begin
                        s       <= 1'b0;
                        s_valid <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    s       <= 1'b0;
                    s_valid <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fivediv_enc.md
FIVEDIV_ENC -- requirements
Module: fivediv_enc

Interface
REQ-001 Parameter DATA_W, default 8, number of payload bits per frame (DATA_W >= 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 start  input  1  frame request; honoured only in IDLE.
REQ-005 data  input  DATA_W  payload, captured on the edge that accepts start.
REQ-006 s  output  1  serial frame bit, MSB first, registered.
REQ-007 s_valid  output  1  high while s carries a payload or check bit.
REQ-008 busy  output  1  high in SEND_DATA and SEND_CHECK.
REQ-009 done  output  1  one-cycle pulse after the last check bit.

Function
REQ-010 Each frame SHALL be DATA_W payload bits followed by 3 check bits; the (DATA_W+3)-bit value SHALL be an exact multiple of 5.
REQ-011 The FSM SHALL have four states: IDLE, SEND_DATA, SEND_CHECK, DONE.
REQ-012 IDLE with start=1 at an edge SHALL load data into the shift register, clear the residue, set the bit counter to DATA_W-1, and move to SEND_DATA.
REQ-013 In SEND_DATA, each cycle SHALL present one payload bit, MSB first; the first bit SHALL appear the cycle after start is accepted.
REQ-014 The residue SHALL update per payload bit as r <= (2r + b) mod 5, held in 3 bits with values 0..4 only.
REQ-015 After the last payload bit, the check value SHALL be c = (2r) mod 5, the final residue doubled mod 5 (since -8 mod 5 = 2); c SHALL be sent as 3 bits, MSB first, over 3 cycles in SEND_CHECK.
REQ-016 The cycle after the last check bit SHALL be DONE: done=1, s=0, s_valid=0, busy=0; the next state SHALL be IDLE unconditionally.
REQ-017 Frame latency: start accepted at edge T; payload bits in cycles T+1..T+DATA_W; check bits in the next 3 cycles; done in cycle T+DATA_W+4.
REQ-018 start in SEND_DATA, SEND_CHECK or DONE SHALL be ignored, and is not queued.
REQ-019 Changes on data after the accepting edge SHALL NOT affect the frame in flight.
REQ-020 Continuously high start SHALL give one idle cycle between frames: done cycle, then IDLE accepts, then the next frame.
REQ-021 Outside SEND_DATA and SEND_CHECK: s=0, s_valid=0.

Reset
REQ-022 reset=0 at an edge SHALL force IDLE, s=0, s_valid=0, busy=0, done=0, and clear the residue and counter, from any state.
REQ-023 A reset mid-frame SHALL abandon the frame with no done pulse; the first start after reset deasserts SHALL begin a fresh frame.
REQ-024 reset SHALL take priority over start on the same edge.

Structure
REQ-025 Package fivediv_pkg SHALL hold the state enum, MOD=5, CHK_W=3, and the function next_residue(r, b) = (2r + b) mod 5.
REQ-026 One sub-module, mod5_residue (3-bit residue register with clear and bit-step), SHALL be instantiated.
REQ-027 mod5_residue SHALL be reusable by the serial divisibility checker.
REQ-028 All remaining logic SHALL be in the top-level module.

Verification
REQ-029 data=8'h03, start pulse -> s = 0000_0011 then 001 (value 25); done exactly 12 cycles after the start edge.
REQ-030 data=8'hAB -> 1010_1011 then 010 (1370); data=8'h05 -> 0000_0101 then 000 (40); data=8'hFF -> check 000 (2040).
REQ-031 Start held high for 3 frames with data=8'h01 -> every frame is 0000_0001 then 010; exactly one idle cycle between done and the next s_valid.
REQ-032 reset=0 during payload bit 4 of data=8'hAB -> next edge s=0, s_valid=0, busy=0, no done; a new frame with data=8'h03 is correct.
REQ-033 start pulsed mid-frame and data changed mid-frame -> frame unaltered, no extra frame.
REQ-034 Loopback into the serial divisibility checker for all 256 data values (residue cleared per frame) -> checker reports divisible after the 11th bit of every frame.
